// File: rtl/reg_ers_bank_if.sv
// Bus bundle for reg_ers_bank: control/data inputs and the three channel outputs.
interface reg_ers_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] d;
  logic             entrada;
  logic             desp_carga;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] salida_sipo;
  logic             salida_piso;

  modport master (
    output enable, d, entrada, desp_carga,
    input  q, salida_sipo, salida_piso
  );

  modport slave (
    input  enable, d, entrada, desp_carga,
    output q, salida_sipo, salida_piso
  );
endinterface

// File: rtl/reg_ers_bank.sv
// Register bank: PIPO holding register, SIPO shift register and PISO shift
// register sharing one clock, one asynchronous reset and one clock enable.
module reg_ers_bank #(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  reg_ers_bank_if.slave bus
);

  logic [WIDTH-1:0] pipo_q;
  logic [WIDTH-1:0] sipo_q;
  logic [WIDTH-1:0] piso_q;

  // PIPO: capture the parallel word on enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pipo_q <= '0;
    else if (bus.enable)
      pipo_q <= bus.d;
  end

  // SIPO: shift left, serial bit enters at the LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sipo_q <= '0;
    else if (bus.enable)
      sipo_q <= {sipo_q[WIDTH-2:0], bus.entrada};
  end

  // PISO: parallel load or shift left with zero fill; MSB is the serial output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      piso_q <= '0;
    else if (bus.enable) begin
      if (bus.desp_carga)
        piso_q <= bus.d;
      else
        piso_q <= {piso_q[WIDTH-2:0], 1'b0};
    end
  end

  assign bus.q           = pipo_q;
  assign bus.salida_sipo = sipo_q;
  assign bus.salida_piso = piso_q[WIDTH-1];

endmodule

// File: tb/tb_reg_ers_bank.sv
// Directed self-checking bench for reg_ers_bank (WIDTH=4).
module tb_reg_ers_bank;
  localparam int unsigned WIDTH = 4;

  logic clk;
  logic reset;
  logic loop;
  logic entrada_drv;
  int   n_checks;
  int   n_pass;

  reg_ers_bank_if #(.WIDTH(WIDTH)) ifc ();

  reg_ers_bank #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Serial input comes either from the bench or from the PISO output (loopback).
  assign ifc.entrada = loop ? ifc.salida_piso : entrada_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges (called #1 after an edge).
  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    loop            = 1'b0;
    entrada_drv     = 1'b0;
    reset           = 1'b1;
    ifc.enable      = 1'b0;
    ifc.d           = '0;
    ifc.desp_carga  = 1'b0;
    #12;
    reset = 1'b0;
    check("rst_q",    ifc.q,           4'b0000);
    check("rst_sipo", ifc.salida_sipo, 4'b0000);
    check("rst_piso", ifc.salida_piso, 1'b0);

    // Preload everything non-zero, then async reset between edges.
    ifc.enable = 1'b1; ifc.d = 4'b1111; entrada_drv = 1'b1; ifc.desp_carga = 1'b1;
    step();
    step();
    check("pre_q",    ifc.q,           4'b1111);
    check("pre_sipo", ifc.salida_sipo, 4'b0011);
    check("pre_piso", ifc.salida_piso, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_q",    ifc.q,           4'b0000);
    check("async_sipo", ifc.salida_sipo, 4'b0000);
    check("async_piso", ifc.salida_piso, 1'b0);
    reset = 1'b0;
    step();

    // PIPO capture and hold.
    ifc.desp_carga = 1'b0; entrada_drv = 1'b0;
    ifc.d = 4'b1010; ifc.enable = 1'b1; step();
    check("pipo_cap", ifc.q, 4'b1010);
    ifc.d = 4'b0010; ifc.enable = 1'b0; step();
    check("pipo_hold", ifc.q, 4'b1010);
    ifc.d = 4'b0011; ifc.enable = 1'b1; step();
    check("pipo_cap2", ifc.q, 4'b0011);

    // SIPO fill from reset.
    pulse_reset();
    ifc.enable = 1'b1; ifc.d = '0;
    entrada_drv = 1'b1; step(); check("sipo_1", ifc.salida_sipo, 4'b0001);
    entrada_drv = 1'b0; step(); check("sipo_2", ifc.salida_sipo, 4'b0010);
    entrada_drv = 1'b1; step(); check("sipo_3", ifc.salida_sipo, 4'b0101);
    entrada_drv = 1'b1; step(); check("sipo_4", ifc.salida_sipo, 4'b1011);
    entrada_drv = 1'b0;

    // PISO serialise 1010 MSB first, then zero.
    ifc.d = 4'b1010; ifc.desp_carga = 1'b1; step();
    check("piso_load", ifc.salida_piso, 1'b1);
    ifc.desp_carga = 1'b0; ifc.d = 4'b1111;
    step(); check("piso_s1", ifc.salida_piso, 1'b0);
    step(); check("piso_s2", ifc.salida_piso, 1'b1);
    step(); check("piso_s3", ifc.salida_piso, 1'b0);
    step(); check("piso_s4", ifc.salida_piso, 1'b0);
    step(); check("piso_s5", ifc.salida_piso, 1'b0);

    // Enable=0 blocks a PISO load: reg 0100 must survive, not become 0110.
    pulse_reset();
    ifc.d = 4'b1010; ifc.desp_carga = 1'b1; ifc.enable = 1'b1; step();
    ifc.desp_carga = 1'b0; step();
    check("blk_pre", ifc.salida_piso, 1'b0);
    ifc.d = 4'b0110; ifc.desp_carga = 1'b1; ifc.enable = 1'b0; step();
    check("blk_piso", ifc.salida_piso, 1'b0);
    check("blk_q", ifc.q, 4'b1010);
    ifc.desp_carga = 1'b0; ifc.enable = 1'b1;
    step(); check("blk_s1", ifc.salida_piso, 1'b1);
    step(); check("blk_s2", ifc.salida_piso, 1'b0);

    // Reset asserted mid-shift: output drops at once, later shifts stay 0.
    ifc.d = 4'b1010; ifc.desp_carga = 1'b1; step();
    ifc.desp_carga = 1'b0; step(); step();
    check("mid_pre", ifc.salida_piso, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst", ifc.salida_piso, 1'b0);
    reset = 1'b0;
    step(); check("mid_s1", ifc.salida_piso, 1'b0);
    step(); check("mid_s2", ifc.salida_piso, 1'b0);

    // Loopback PISO -> SIPO.
    pulse_reset();
    loop = 1'b1;
    ifc.d = 4'b1010; ifc.desp_carga = 1'b1; step();
    ifc.desp_carga = 1'b0;
    step(); step(); step(); step();
    check("loop", ifc.salida_sipo, 4'b1010);

    // Loopback with a stalled edge mid-sequence.
    pulse_reset();
    ifc.desp_carga = 1'b1; step();
    ifc.desp_carga = 1'b0;
    step(); step();
    check("loop_mid", ifc.salida_sipo, 4'b0010);
    ifc.enable = 1'b0; step();
    check("loop_stall", ifc.salida_sipo, 4'b0010);
    ifc.enable = 1'b1;
    step(); step();
    check("loop_stall_end", ifc.salida_sipo, 4'b1010);
    loop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
